burst_mode_ctrl: RTL and testbench
==================================

# burst_mode_ctrl

Sequencing FSM for the burst-mode memory datapath. After reset it waits out the CellularRAM power-up time and writes the Bus Configuration Register through the datapath's Con mode. It then serves single-burst read/write requests by stepping the datapath Mode through Address → Read/Write → Idle while driving the memory control strobes, honouring the WAIT pin. It sits between the memory-controller front end (requester) and the datapath/external pins.

## Interface
- PowerUpCycles, 15000, clocks held in PWRUP before configuration (150 µs at 100 MHz)
- CfgPulseCycles, 4, clocks CE#/ADV#/WE#/CRE held asserted for the BCR write
- LatCount, 3, initial-latency clocks after the address cycle; must equal the BCR LatCount field
- BurstLen, 16, words per burst (2..256)
- WaitTimeout, 64, consecutive WAIT-high clocks in DATA before abort
- Clk  in  1  system clock; memory CLK is Clk gated by MemClkEn
- ResetN  in  1  reset, synchronous, active-low
- Start  in  1  request; accepted only when Ready=1
- RW  in  1  1=read, 0=write; sampled with Start
- MemWait  in  1  memory WAIT, active-high (WaitPol=1)
- Ready  out  1  idle and configured
- Done  out  1  one-clock pulse at burst end
- Error  out  1  one-clock pulse with Done on WAIT timeout
- WordValid  out  1  one clock per data beat transferred
- WordIndex  out  8  beat number of the current WordValid, 0..BurstLen-1
- ConfigDone  out  1  sticky after the BCR write, cleared by reset
- Mode  out  3  datapath mode: Idle 000, Read 001, Con 010, Write 011, Address 100
- MemCE_n, MemADV_n, MemOE_n, MemWE_n  out  1 each  memory strobes, active-low
- MemCRE  out  1  control-register enable
- MemClkEn  out  1  memory clock enable

## Operation
- Reset values, applied on the first Clk edge with ResetN=0: Mode=000; CE_n/ADV_n/OE_n/WE_n=1; CRE=0; MemClkEn=0; Ready/Done/Error/WordValid/ConfigDone=0; WordIndex=0. FSM enters PWRUP.
- Reset mid-operation aborts immediately. No Done is issued. The full PWRUP and CFG sequence reruns.
- PWRUP: count PowerUpCycles, then → CFG_SETUP.
- CFG_SETUP (1 clk): Mode=Con, CRE=1, strobes high. → CFG_WR.
- CFG_WR (CfgPulseCycles clks): Mode=Con, CRE=1, CE_n=0, ADV_n=0, WE_n=0. → CFG_END.
- CFG_END (1 clk): strobes high, CRE=0, Mode=Idle; ConfigDone set. → IDLE.
- IDLE: Ready=1. Start=1 latches RW. → ADDR.
- ADDR (1 clk): Mode=Address, MemClkEn=1, CE_n=0, ADV_n=0. WE_n=0 if write, else OE_n stays high. → LAT.
- LAT (LatCount clks): Mode=Read or Write, CE_n=0, ADV_n=1. OE_n=0 for reads. → DATA.
- DATA: same outputs as LAT.
  - Each clock with MemWait=0 is a beat: WordValid=1, WordIndex=beat count.
  - MemWait=1 stalls with no beat and increments the timeout counter. Any beat clears the counter.
  - Beat BurstLen-1 → DONE. Timeout counter reaching WaitTimeout → DONE with Error.
- DONE (1 clk): Done=1 (Error=1 if aborted), CE_n=1, OE_n=1, MemClkEn=0, Mode=Idle. → IDLE.
- Start while Ready=0 is ignored and is not queued.
- RW changes after acceptance have no effect.
- WordIndex is 8-bit and never wraps within a burst. It resets to 0 in ADDR.

## Timing
- Start sampled at edge N (Ready=1) → ADDR outputs valid after edge N; Ready=0 from edge N.
- First possible beat is LatCount+1 clocks after the ADDR cycle.
- With no WAIT stalls, Start to Done = 1 + LatCount + BurstLen + 1 clocks.
- Ready is 1 in the clock after DONE; back-to-back bursts therefore have a 1-clock gap.
- Configuration: ConfigDone rises PowerUpCycles+CfgPulseCycles+2 clocks after reset release.
- All outputs are registered. No combinational path from an input to an output.

## Structure
- Package burst_mode_pkg holds:
  - Mode encodings, matching the datapath: Idle/Read/Con/Write/Address.
  - FSM state enum: PWRUP, CFG_SETUP, CFG_WR, CFG_END, IDLE, ADDR, LAT, DATA, DONE.
  - Default parameter values.
- One sub-module, burst_cycle_timer, is natural: a loadable down-counter with a zero flag. It is shared by PWRUP, CFG_WR and LAT, and is sized for PowerUpCycles.
- Beat and timeout counters stay in the top FSM.

## Test plan
- Reset release with PowerUpCycles=10, CfgPulseCycles=4:
  - CFG_SETUP occurs at clk 10.
  - CE_n/ADV_n/WE_n are low and CRE=1 for clks 11–14, with Mode=010 throughout CFG_SETUP and CFG_WR.
  - ConfigDone=1 and Ready=1 at clk 16.
- Read, LatCount=3, BurstLen=16, MemWait=0:
  - ADV_n low exactly 1 clk; OE_n low for 19 clks.
  - 16 WordValid pulses with WordIndex 0..15.
  - Done 21 clks after Start.
- Write with MemWait=1 for 5 clks after beat 3:
  - WordIndex holds at 3, then beats resume at 4.
  - Done is delayed exactly 5 clks; Error=0.
- MemWait stuck high in DATA, WaitTimeout=64:
  - Done and Error pulse together after 64 stall clks.
  - All strobes are high on the next clk.
- Start asserted during DATA and during CFG_WR: ignored, no second burst. ResetN=0 mid-DATA: all outputs take reset values at the next edge and PWRUP restarts.

Source files
------------

// File: rtl/burst_mode_pkg.sv
// rtl/burst_mode_pkg.sv - shared encodings and default timing for the burst-mode sequencer
package burst_mode_pkg;

  typedef enum logic [2:0] {
    ModeIdle  = 3'b000,
    ModeRead  = 3'b001,
    ModeCon   = 3'b010,
    ModeWrite = 3'b011,
    ModeAddr  = 3'b100
  } modeT;

  typedef enum logic [3:0] {
    PWRUP, CFG_SETUP, CFG_WR, CFG_END, IDLE, ADDR, LAT, DATA, DONE
  } stateT;

  localparam int DefPowerUpCycles  = 15000;
  localparam int DefCfgPulseCycles = 4;
  localparam int DefLatCount       = 3;
  localparam int DefBurstLen       = 16;
  localparam int DefWaitTimeout    = 64;

endpackage

// File: rtl/burst_mode_ctrl_if.sv
// rtl/burst_mode_ctrl_if.sv - requester handshake and memory pin bundle
interface burst_mode_ctrl_if;
  import burst_mode_pkg::*;

  logic       Start;
  logic       RW;
  logic       MemWait;
  logic       Ready;
  logic       Done;
  logic       Error;
  logic       WordValid;
  logic [7:0] WordIndex;
  logic       ConfigDone;
  modeT       Mode;
  logic       MemCE_n;
  logic       MemADV_n;
  logic       MemOE_n;
  logic       MemWE_n;
  logic       MemCRE;
  logic       MemClkEn;

  modport master (
    output Start, RW, MemWait,
    input  Ready, Done, Error, WordValid, WordIndex, ConfigDone, Mode,
           MemCE_n, MemADV_n, MemOE_n, MemWE_n, MemCRE, MemClkEn
  );

  modport slave (
    input  Start, RW, MemWait,
    output Ready, Done, Error, WordValid, WordIndex, ConfigDone, Mode,
           MemCE_n, MemADV_n, MemOE_n, MemWE_n, MemCRE, MemClkEn
  );

endinterface

// File: rtl/burst_cycle_timer.sv
// rtl/burst_cycle_timer.sv - loadable down-counter with a zero flag, shared by power-up, BCR pulse and latency
module burst_cycle_timer #(
  parameter int              Width    = 14,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Load,
  input  logic [Width-1:0] LoadVal,
  output logic             IsZero
);

  logic [Width-1:0] count;

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      count <= ResetVal;
    end else if (Load) begin
      count <= LoadVal;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign IsZero = (count == '0);

endmodule

// File: rtl/burst_mode_ctrl.sv
// rtl/burst_mode_ctrl.sv - power-up, BCR write and single-burst sequencing for the CellularRAM datapath
module burst_mode_ctrl
  import burst_mode_pkg::*;
#(
  parameter int PowerUpCycles  = DefPowerUpCycles,
  parameter int CfgPulseCycles = DefCfgPulseCycles,
  parameter int LatCount       = DefLatCount,
  parameter int BurstLen       = DefBurstLen,
  parameter int WaitTimeout    = DefWaitTimeout
) (
  input  logic             Clk,
  input  logic             ResetN,
  burst_mode_ctrl_if.slave bus
);

  localparam int TimerW = $clog2(PowerUpCycles + 1);
  localparam int WaitW  = $clog2(WaitTimeout + 1);
  localparam logic [TimerW-1:0] PwrLoad  = TimerW'(PowerUpCycles - 1);
  localparam logic [TimerW-1:0] CfgLoad  = TimerW'(CfgPulseCycles - 1);
  localparam logic [TimerW-1:0] LatLoad  = TimerW'(LatCount - 1);
  localparam logic [7:0]        LastBeat = 8'(BurstLen - 1);
  localparam logic [WaitW-1:0]  WaitLast = WaitW'(WaitTimeout - 1);

  stateT             state;
  logic              rwLatched;
  logic [7:0]        beatCnt;
  logic [WaitW-1:0]  waitCnt;
  logic              tmrLoad;
  logic [TimerW-1:0] tmrLoadVal;
  logic              tmrZero;
  logic              lastBeat;
  logic              timedOut;

  // CFG_SETUP and ADDR are single-clock states, so they double as the load strobe for the next timed state
  assign tmrLoad    = (state == CFG_SETUP) || (state == ADDR);
  assign tmrLoadVal = (state == CFG_SETUP) ? CfgLoad : LatLoad;
  assign lastBeat   = !bus.MemWait && (beatCnt == LastBeat);
  assign timedOut   = bus.MemWait && (waitCnt == WaitLast);

  burst_cycle_timer #(
    .Width    (TimerW),
    .ResetVal (PwrLoad)
  ) u_timer (
    .Clk     (Clk),
    .ResetN  (ResetN),
    .Load    (tmrLoad),
    .LoadVal (tmrLoadVal),
    .IsZero  (tmrZero)
  );

  // Outputs are assigned on the edge that enters a state, so each state's pin values are registered
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state          <= PWRUP;
      rwLatched      <= 1'b0;
      beatCnt        <= '0;
      waitCnt        <= '0;
      bus.Ready      <= 1'b0;
      bus.Done       <= 1'b0;
      bus.Error      <= 1'b0;
      bus.WordValid  <= 1'b0;
      bus.WordIndex  <= '0;
      bus.ConfigDone <= 1'b0;
      bus.Mode       <= ModeIdle;
      bus.MemCE_n    <= 1'b1;
      bus.MemADV_n   <= 1'b1;
      bus.MemOE_n    <= 1'b1;
      bus.MemWE_n    <= 1'b1;
      bus.MemCRE     <= 1'b0;
      bus.MemClkEn   <= 1'b0;
    end else begin
      bus.Done      <= 1'b0;
      bus.Error     <= 1'b0;
      bus.WordValid <= 1'b0;
      case (state)
        PWRUP: if (tmrZero) begin
          state      <= CFG_SETUP;
          bus.Mode   <= ModeCon;
          bus.MemCRE <= 1'b1;
        end
        CFG_SETUP: begin
          state        <= CFG_WR;
          bus.MemCE_n  <= 1'b0;
          bus.MemADV_n <= 1'b0;
          bus.MemWE_n  <= 1'b0;
        end
        CFG_WR: if (tmrZero) begin
          state        <= CFG_END;
          bus.MemCE_n  <= 1'b1;
          bus.MemADV_n <= 1'b1;
          bus.MemWE_n  <= 1'b1;
          bus.MemCRE   <= 1'b0;
          bus.Mode     <= ModeIdle;
        end
        CFG_END: begin
          state          <= IDLE;
          bus.ConfigDone <= 1'b1;
          bus.Ready      <= 1'b1;
        end
        IDLE: if (bus.Start) begin
          state         <= ADDR;
          rwLatched     <= bus.RW;
          bus.Ready     <= 1'b0;
          bus.Mode      <= ModeAddr;
          bus.MemClkEn  <= 1'b1;
          bus.MemCE_n   <= 1'b0;
          bus.MemADV_n  <= 1'b0;
          bus.MemWE_n   <= bus.RW;
          bus.WordIndex <= '0;
          beatCnt       <= '0;
          waitCnt       <= '0;
        end
        ADDR: begin
          state        <= LAT;
          bus.Mode     <= rwLatched ? ModeRead : ModeWrite;
          bus.MemADV_n <= 1'b1;
          bus.MemWE_n  <= 1'b1;
          bus.MemOE_n  <= !rwLatched;
        end
        LAT: if (tmrZero) begin
          state <= DATA;
        end
        DATA: begin
          if (!bus.MemWait) begin
            bus.WordValid <= 1'b1;
            bus.WordIndex <= beatCnt;
            beatCnt       <= beatCnt + 1'b1;
            waitCnt       <= '0;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
          if (lastBeat || timedOut) begin
            state        <= DONE;
            bus.Done     <= 1'b1;
            bus.Error    <= timedOut;
            bus.MemCE_n  <= 1'b1;
            bus.MemOE_n  <= 1'b1;
            bus.MemClkEn <= 1'b0;
            bus.Mode     <= ModeIdle;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.Ready <= 1'b1;
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_mode_ctrl.sv
// tb/tb_burst_mode_ctrl.sv - directed self-checking bench for burst_mode_ctrl
module tb_burst_mode_ctrl;

  logic Clk = 1'b0;
  logic ResetN;
  int   checks = 0;
  int   errors = 0;

  burst_mode_ctrl_if bus ();

  burst_mode_ctrl #(
    .PowerUpCycles  (10),
    .CfgPulseCycles (4),
    .LatCount       (3),
    .BurstLen       (16),
    .WaitTimeout    (64)
  ) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  localparam logic [21:0] ResetVec = {3'b000, 6'b111100, 5'b00000, 8'h00};

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [21:0] outVec();
    return {3'(bus.Mode), bus.MemCE_n, bus.MemADV_n, bus.MemOE_n, bus.MemWE_n, bus.MemCRE,
            bus.MemClkEn, bus.Ready, bus.Done, bus.Error, bus.WordValid, bus.ConfigDone,
            bus.WordIndex};
  endfunction

  task automatic runBurst(input logic rw, input logic stuck, input int stallBeat, input int stallLen,
                          input int reStartAt, output int doneAt, output int beats, output int idxErr,
                          output int advLow, output int oeLow, output int weLow, output int modeErr,
                          output int holdErr, output logic errFlag);
    int         stallLeft;
    logic [2:0] m;
    logic [2:0] expMode;
    doneAt = -1; beats = 0; idxErr = 0; advLow = 0; oeLow = 0; weLow = 0;
    modeErr = 0; holdErr = 0; errFlag = 1'b0; stallLeft = 0;
    expMode = rw ? 3'b001 : 3'b011;
    bus.Start = 1'b1; bus.RW = rw; bus.MemWait = stuck;
    for (int k = 1; k <= 120 && doneAt < 0; k++) begin
      tick();
      if (k == 1) begin
        bus.Start = 1'b0;
        bus.RW    = !rw;
      end
      if (k == reStartAt) bus.Start = 1'b1;
      else if (k == reStartAt + 1) bus.Start = 1'b0;
      m = bus.Mode;
      if (!bus.MemADV_n) advLow++;
      if (!bus.MemOE_n) oeLow++;
      if (!bus.MemWE_n) weLow++;
      if (!bus.MemCE_n && bus.MemADV_n && m != expMode) modeErr++;
      if (stallLeft > 0 && (bus.WordValid || bus.WordIndex != 8'(stallBeat))) holdErr++;
      if (bus.WordValid) begin
        if (bus.WordIndex != 8'(beats)) idxErr++;
        beats++;
      end
      if (bus.Done) begin
        doneAt  = k;
        errFlag = bus.Error;
      end
      if (stallLeft > 0) begin
        stallLeft--;
        if (stallLeft == 0) bus.MemWait = 1'b0;
      end else if (stallLen > 0 && bus.WordValid && bus.WordIndex == 8'(stallBeat)) begin
        bus.MemWait = 1'b1;
        stallLeft   = stallLen;
      end
    end
  endtask

  int   doneAt, beats, idxErr, advLow, oeLow, weLow, modeErr, holdErr, cfgBad, n;
  logic errFlag;
  logic doneSeen;

  initial begin
    ResetN = 1'b0; bus.Start = 1'b0; bus.RW = 1'b0; bus.MemWait = 1'b0;
    repeat (3) tick();
    checkEq("reset_outputs", 32'(outVec()), 32'(ResetVec));

    ResetN = 1'b1;
    cfgBad = 0;
    for (int c = 0; c <= 16; c++) begin
      if (c == 9)  checkEq("pwrup_mode", 32'(bus.Mode), 0);
      if (c == 10) begin
        checkEq("cfg_setup_mode", 32'(bus.Mode), 2);
        checkEq("cfg_setup_cre", 32'(bus.MemCRE), 1);
        checkEq("cfg_setup_ce", 32'(bus.MemCE_n), 1);
      end
      if (c >= 11 && c <= 14 &&
          {bus.MemCE_n, bus.MemADV_n, bus.MemWE_n, bus.MemCRE, 3'(bus.Mode)} != 7'b0001010)
        cfgBad++;
      if (c == 15) begin
        checkEq("cfg_end_strobes", 32'({bus.MemCE_n, bus.MemADV_n, bus.MemWE_n, bus.MemCRE}), 32'b1110);
        checkEq("cfg_end_mode", 32'(bus.Mode), 0);
        checkEq("cfg_end_cfgdone", 32'(bus.ConfigDone), 0);
      end
      if (c == 16) begin
        checkEq("cfg_done", 32'(bus.ConfigDone), 1);
        checkEq("cfg_ready", 32'(bus.Ready), 1);
        checkEq("cfg_start_ignored", 32'(bus.Mode), 0);
      end
      if (c == 12) bus.Start = 1'b1;
      else if (c == 13) bus.Start = 1'b0;
      if (c < 16) tick();
    end
    checkEq("cfg_wr_strobes", cfgBad, 0);

    // read, no stalls, stray Start in DATA
    runBurst(1'b1, 1'b0, 0, 0, 10, doneAt, beats, idxErr, advLow, oeLow, weLow, modeErr, holdErr, errFlag);
    checkEq("rd_done_at", doneAt, 21);
    checkEq("rd_beats", beats, 16);
    checkEq("rd_index_seq", idxErr, 0);
    checkEq("rd_adv_low", advLow, 1);
    checkEq("rd_oe_low", oeLow, 19);
    checkEq("rd_we_low", weLow, 0);
    checkEq("rd_mode", modeErr, 0);
    checkEq("rd_error", 32'(errFlag), 0);
    tick();
    checkEq("rd_ready_after", 32'(bus.Ready), 1);
    tick(); tick();
    checkEq("rd_no_second_burst", 32'({3'(bus.Mode), bus.MemCE_n, bus.Ready}), 32'b00011);

    // write, five WAIT clocks after beat 3
    runBurst(1'b0, 1'b0, 3, 5, 0, doneAt, beats, idxErr, advLow, oeLow, weLow, modeErr, holdErr, errFlag);
    checkEq("wr_done_at", doneAt, 26);
    checkEq("wr_beats", beats, 16);
    checkEq("wr_index_seq", idxErr, 0);
    checkEq("wr_index_hold", holdErr, 0);
    checkEq("wr_we_low", weLow, 1);
    checkEq("wr_oe_low", oeLow, 0);
    checkEq("wr_mode", modeErr, 0);
    checkEq("wr_error", 32'(errFlag), 0);
    tick();

    // WAIT stuck high: timeout
    runBurst(1'b1, 1'b1, 0, 0, 0, doneAt, beats, idxErr, advLow, oeLow, weLow, modeErr, holdErr, errFlag);
    checkEq("to_done_at", doneAt, 69);
    checkEq("to_error", 32'(errFlag), 1);
    checkEq("to_beats", beats, 0);
    tick();
    checkEq("to_strobes_idle", 32'({bus.MemCE_n, bus.MemADV_n, bus.MemOE_n, bus.MemWE_n, bus.MemCRE, bus.MemClkEn}),
            32'b111100);
    checkEq("to_error_pulse", 32'(bus.Error), 0);
    bus.MemWait = 1'b0;

    // reset in the middle of DATA
    bus.Start = 1'b1; bus.RW = 1'b1;
    tick();
    bus.Start = 1'b0;
    repeat (7) tick();
    checkEq("mid_wordvalid", 32'(bus.WordValid), 1);
    ResetN = 1'b0;
    tick();
    checkEq("mid_reset_outputs", 32'(outVec()), 32'(ResetVec));
    ResetN = 1'b1;
    doneSeen = 1'b0;
    n = 0;
    while (n <= 40 && !bus.ConfigDone) begin
      if (bus.Done) doneSeen = 1'b1;
      tick();
      n++;
    end
    checkEq("rerun_cfg_time", n, 16);
    checkEq("rerun_no_done", 32'(doneSeen), 0);
    checkEq("rerun_ready", 32'(bus.Ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
